// File: rtl/rv_pkg.sv
// rv_pkg: types and constants shared by the RV32IM soft processor blocks.
//   XLEN          - architectural register / PC width
//   NOP_INSTR     - canonical NOP (addi x0, x0, 0)
//   fetch_state_t - fetch-stage control states
//   fetch_entry_t - one fetched instruction with its PC
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_stage_fetch_buffer.sv
// fetch_buffer: 2-entry {pc, instr} FIFO absorbing the BRAM read latency.
//   clock, reset : clock / async active-high reset (storage cleared to zero)
//   push, wdata  : write an entry at the tail
//   pop          : drop the head entry (same-cycle push and pop allowed)
//   flush        : discard everything; wins over push and pop
//   count        : occupancy 0..2
//   head         : oldest entry (zero after reset)
module fetch_buffer
    import rv_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t ent [2];
    logic         wr_ptr;
    logic         rd_ptr;

    assign head = ent[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent[0] <= '0;
            ent[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                ent[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/rv_fetch_stage.sv
// rv_fetch_stage: instruction fetch for the RV32IM core.
// Keeps the PC, issues at most one BRAM read per cycle, parks returning
// words in a 2-entry buffer and hands them to decode under valid/ready.
// Redirects flush the buffer; a misaligned target halts fetch with fault.
//   clock, reset              : clock / async active-high reset
//   mem_addr, mem_en          : BRAM word address and read enable
//   mem_rdata                 : BRAM data, one cycle after the issue
//   redirect_valid/_pc        : flush and restart at redirect_pc
//   out_valid/_ready          : decode handshake
//   out_pc, out_instr         : presented instruction
//   fault                     : halted on misaligned redirect
module rv_fetch_stage
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_en,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_instr,
    output logic                  fault
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;     // PC of the read currently in flight
    logic            inflight;
    logic            req_epoch;  // epoch the in-flight read was issued under
    logic            epoch;
    logic [1:0]      count;
    logic [2:0]      occ_after;
    logic            fire;
    logic            resp_live;
    logic            redir_ok;
    logic            issue;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    assign fire     = out_valid & out_ready;
    assign redir_ok = redirect_pc[1:0] == 2'b00;

    // A response is kept only if no flush happened since it was issued:
    // a redirect this cycle kills it directly, an older one via the epoch.
    assign resp_live = inflight & (req_epoch == epoch) & ~redirect_valid;

    // Occupancy once this cycle settles; issuing is safe while that leaves
    // room for the word that will return next cycle.
    assign occ_after = {1'b0, count} + {2'b00, resp_live} - {2'b00, fire};
    assign issue     = (state == RUN) & ~redirect_valid & (occ_after < 3'd2);

    assign mem_en   = issue;
    assign mem_addr = pc[ADDR_WIDTH+1:2];

    always_comb begin
        state_nxt = state;
        if (state == BOOT)
            state_nxt = RUN;
        if (redirect_valid)
            state_nxt = redir_ok ? RUN : HALT;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            req_pc    <= '0;
            inflight  <= 1'b0;
            req_epoch <= 1'b0;
            epoch     <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (issue) begin
                req_pc    <= pc;
                req_epoch <= epoch;
                pc        <= pc + 32'd4;
            end
            if (redirect_valid) begin
                epoch <= ~epoch;
                if (redir_ok)
                    pc <= redirect_pc;
            end
        end
    end

    assign wr_entry = '{pc: req_pc, instr: mem_rdata};

    fetch_buffer u_buf (
        .clock (clock),
        .reset (reset),
        .push  (resp_live),
        .pop   (fire),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .count (count),
        .head  (head)
    );

    // The buffer is flushed on entry to HALT and nothing is issued there,
    // so an empty buffer already covers out_valid in HALT.
    assign out_valid = count != 2'd0;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign fault     = state == HALT;

endmodule

// File: tb/tb_rv_fetch_stage.sv
module tb_rv_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  mem_addr;
    logic        mem_en;
    logic [31:0] mem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;

    int n_total = 0;
    int n_pass  = 0;
    int n_fires = 0;

    logic [31:0] bram [1024];
    logic [31:0] words [8];

    // reference model state
    exp_t        exp_q [$];
    logic [31:0] m_pc;
    logic        m_halt;
    logic        have_prev;
    logic        prev_valid, prev_fire, prev_redir;
    logic [31:0] prev_pc, prev_instr;

    rv_fetch_stage #(.RESET_PC(32'h0), .ADDR_WIDTH(10)) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_en         (mem_en),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fault          (fault)
    );

    always #5 clock = ~clock;

    // synchronous-read BRAM, no output register
    always @(posedge clock) begin
        if (mem_en) mem_rdata <= bram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        // only pc[11:2] reaches the 1024-word BRAM
        return bram[pc[11:2]];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc      = 32'h0;
        m_halt    = 1'b0;
        have_prev = 1'b0;
    endtask

    // Scoreboard: expected stream is the sequential PC walk from the last
    // restart point; redirects discard whatever was still expected.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("fault_state", {31'b0, fault}, {31'b0, m_halt});
                if (m_halt) begin
                    check("halt_out_valid", {31'b0, out_valid}, 32'd0);
                    check("halt_mem_en", {31'b0, mem_en}, 32'd0);
                end
                if (have_prev && prev_valid && !prev_fire && !prev_redir) begin
                    check("hold_valid", {31'b0, out_valid}, 32'd1);
                    check("hold_pc", out_pc, prev_pc);
                    check("hold_instr", out_instr, prev_instr);
                end
                if (out_valid && out_ready) begin
                    n_fires++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", out_pc, 32'hxxxx_xxxx);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("sb_pc", out_pc, e.pc);
                        check("sb_instr", out_instr, e.instr);
                    end
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    if (redirect_pc[1:0] == 2'b00) begin
                        m_pc   = redirect_pc;
                        m_halt = 1'b0;
                    end else begin
                        m_halt = 1'b1;
                    end
                end
                if (!m_halt) begin
                    while (exp_q.size() < 4) begin
                        exp_q.push_back('{pc: m_pc, instr: word_at(m_pc)});
                        m_pc = m_pc + 32'd4;
                    end
                end
                have_prev  = 1'b1;
                prev_valid = out_valid;
                prev_fire  = out_valid && out_ready;
                prev_redir = redirect_valid;
                prev_pc    = out_pc;
                prev_instr = out_instr;
            end
        end
    end

    // one cycle: drive after the edge, return at the following negedge
    task automatic next_cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clock);
        #1;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clock);
    endtask

    // asserts reset after an edge, checks outputs at once, releases;
    // returns at the negedge of cycle 0 (BOOT)
    task automatic do_reset(input logic rdy);
        @(posedge clock);
        #1;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        model_reset();
        #1;
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = rdy;
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] tgt;
        words = '{32'h00000093, 32'h00100113, 32'h00000193, 32'h00018A63,
                  32'h00208133, 32'h00000193, 32'h18202823, 32'hFF1FF06F};
        for (int i = 0; i < 1024; i++) bram[i] = $urandom();
        for (int i = 0; i < 8; i++) bram[i] = words[i];
        model_reset();

        // boot sequence and streaming at full rate
        do_reset(1'b1);
        check("boot_mem_en", {31'b0, mem_en}, 32'd0);
        check("boot_valid", {31'b0, out_valid}, 32'd0);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("c1_mem_en", {31'b0, mem_en}, 32'd1);
        check("c1_addr", {22'b0, mem_addr}, 32'd0);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("c2_valid", {31'b0, out_valid}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            next_cyc(1'b1, 1'b0, 32'h0);
            check("stream_valid", {31'b0, out_valid}, 32'd1);
            check("stream_pc", out_pc, 32'(4 * k));
            check("stream_instr", out_instr, words[k]);
        end

        // stall for 5 cycles after the first fire
        do_reset(1'b1);
        next_cyc(1'b1, 1'b0, 32'h0);
        next_cyc(1'b1, 1'b0, 32'h0);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("stall_first_pc", out_pc, 32'h0);
        for (int k = 0; k < 5; k++) begin
            next_cyc(1'b0, 1'b0, 32'h0);
            check("stall_mem_en", {31'b0, mem_en}, 32'd0);
            check("stall_pc", out_pc, 32'h4);
        end
        for (int k = 1; k <= 3; k++) begin
            next_cyc(1'b1, 1'b0, 32'h0);
            check("drain_valid", {31'b0, out_valid}, 32'd1);
            check("drain_pc", out_pc, 32'(4 * k));
        end

        // redirect with one buffered and one in flight
        do_reset(1'b0);
        next_cyc(1'b0, 1'b0, 32'h0);
        next_cyc(1'b0, 1'b0, 32'h0);
        next_cyc(1'b0, 1'b1, 32'h10);
        check("redir_mem_en", {31'b0, mem_en}, 32'd0);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("redir_t1_mem_en", {31'b0, mem_en}, 32'd1);
        check("redir_t1_addr", {22'b0, mem_addr}, 32'd4);
        check("redir_t1_valid", {31'b0, out_valid}, 32'd0);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("redir_t2_valid", {31'b0, out_valid}, 32'd0);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("redir_t3_valid", {31'b0, out_valid}, 32'd1);
        check("redir_t3_pc", out_pc, 32'h10);
        check("redir_t3_instr", out_instr, 32'h00208133);

        // redirect together with the fire of pc 0x8
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) next_cyc(1'b1, 1'b0, 32'h0);
        next_cyc(1'b1, 1'b1, 32'h14);
        check("samecyc_pc", out_pc, 32'h8);
        check("samecyc_valid", {31'b0, out_valid}, 32'd1);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("samecyc_gap1", {31'b0, out_valid}, 32'd0);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("samecyc_gap2", {31'b0, out_valid}, 32'd0);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("samecyc_tgt_pc", out_pc, 32'h14);
        check("samecyc_tgt_instr", out_instr, 32'h00000193);

        // misaligned redirect halts; aligned redirect recovers
        next_cyc(1'b1, 1'b1, 32'h6);
        check("mis_mem_en", {31'b0, mem_en}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            next_cyc(1'b1, 1'b0, 32'h0);
            check("halt_fault", {31'b0, fault}, 32'd1);
            check("halt_valid", {31'b0, out_valid}, 32'd0);
            check("halt_en", {31'b0, mem_en}, 32'd0);
        end
        next_cyc(1'b1, 1'b1, 32'h0);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("recover_fault", {31'b0, fault}, 32'd0);
        check("recover_mem_en", {31'b0, mem_en}, 32'd1);
        check("recover_addr", {22'b0, mem_addr}, 32'd0);
        next_cyc(1'b1, 1'b0, 32'h0);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("recover_pc", out_pc, 32'h0);
        check("recover_instr", out_instr, 32'h00000093);

        // address wrap past BRAM word 1023
        next_cyc(1'b1, 1'b1, 32'hFF8);
        next_cyc(1'b1, 1'b0, 32'h0);
        next_cyc(1'b1, 1'b0, 32'h0);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("wrap_ff8", out_pc, 32'hFF8);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("wrap_ffc", out_pc, 32'hFFC);
        next_cyc(1'b1, 1'b0, 32'h0);
        check("wrap_pc", out_pc, 32'h1000);
        check("wrap_instr", out_instr, 32'h00000093);

        // mid-stream reset, then randomized traffic
        do_reset(1'b1);
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset(1'b1);
            r = $urandom();
            tgt = r[0] ? {20'h0, r[11:2], 2'b00} : {r[31:2], 2'b00};
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            next_cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, tgt);
        end
        next_cyc(1'b1, 1'b0, 32'h0);
        check("rand_fires_seen", {31'b0, n_fires > 500}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
